// File: rtl/axi_lite_arbiter_if.sv
// AXI-lite channel bundle shared by the arbiter's two master ports and its
// slave port. "master" is the side that issues requests; "slave" answers them.
interface axi_lite_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              ar_valid;
  logic [ADDR_W-1:0] ar_addr;
  logic              ar_ready;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_ready;
  logic              aw_valid;
  logic [ADDR_W-1:0] aw_addr;
  logic              aw_ready;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              b_valid;
  logic [1:0]        b_resp;
  logic              b_ready;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master, one-slave AXI-lite arbiter. Whole transactions are serialised:
// one read or one write is outstanding at the slave at a time, and ties are
// broken round-robin against the master that completed last.
//
// state      | meaning
// IDLE       | no grant; choose a master when one requests
// RD_ADDR    | forwarding granted master's ar channel
// RD_DATA    | forwarding r channel back to granted master
// WR_XFER    | forwarding aw and w independently until both accepted
// WR_RESP    | forwarding b channel back to granted master
module axi_lite_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic clk,
  input  logic rst,
  axi_lite_arbiter_if.slave  m0,
  axi_lite_arbiter_if.slave  m1,
  axi_lite_arbiter_if.master s
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_XFER = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  logic [2:0] r_state;
  logic       r_gnt;
  logic       r_last;
  logic       r_aw_done;
  logic       r_w_done;

  logic              w_req0;
  logic              w_req1;
  logic              w_nxt_gnt;
  logic              w_nxt_rd;
  logic              w_st_rd_addr;
  logic              w_st_rd_data;
  logic              w_st_wr_xfer;
  logic              w_st_wr_resp;
  logic              w_sel_ar_valid;
  logic              w_sel_r_ready;
  logic              w_sel_aw_valid;
  logic              w_sel_w_valid;
  logic              w_sel_b_ready;
  logic [ADDR_W-1:0] w_sel_ar_addr;
  logic [ADDR_W-1:0] w_sel_aw_addr;
  logic [DATA_W-1:0] w_sel_w_data;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;

  // Request decode, tie-break and channel selection from the granted master.
  always_comb begin
    w_req0    = m0.ar_valid | m0.aw_valid;
    w_req1    = m1.ar_valid | m1.aw_valid;
    // With only one requester the expression collapses to that requester.
    w_nxt_gnt = (w_req0 & w_req1) ? ~r_last : w_req1;
    // A read wins over a simultaneous write from the same master.
    w_nxt_rd  = w_nxt_gnt ? m1.ar_valid : m0.ar_valid;

    w_st_rd_addr = (r_state == ST_RD_ADDR);
    w_st_rd_data = (r_state == ST_RD_DATA);
    w_st_wr_xfer = (r_state == ST_WR_XFER);
    w_st_wr_resp = (r_state == ST_WR_RESP);

    w_sel_ar_valid = r_gnt ? m1.ar_valid : m0.ar_valid;
    w_sel_r_ready  = r_gnt ? m1.r_ready  : m0.r_ready;
    w_sel_aw_valid = r_gnt ? m1.aw_valid : m0.aw_valid;
    w_sel_w_valid  = r_gnt ? m1.w_valid  : m0.w_valid;
    w_sel_b_ready  = r_gnt ? m1.b_ready  : m0.b_ready;
    w_sel_ar_addr  = r_gnt ? m1.ar_addr  : m0.ar_addr;
    w_sel_aw_addr  = r_gnt ? m1.aw_addr  : m0.aw_addr;
    w_sel_w_data   = r_gnt ? m1.w_data   : m0.w_data;

    w_ar_hs = w_st_rd_addr & w_sel_ar_valid & s.ar_ready;
    w_r_hs  = w_st_rd_data & s.r_valid & w_sel_r_ready;
    w_aw_hs = w_st_wr_xfer & ~r_aw_done & w_sel_aw_valid & s.aw_ready;
    w_w_hs  = w_st_wr_xfer & ~r_w_done & w_sel_w_valid & s.w_ready;
    w_b_hs  = w_st_wr_resp & s.b_valid & w_sel_b_ready;
  end

  // Slave-side forwarding; each valid is owned by exactly one state.
  always_comb begin
    s.ar_valid = w_st_rd_addr & w_sel_ar_valid;
    s.ar_addr  = w_sel_ar_addr;
    s.r_ready  = w_st_rd_data & w_sel_r_ready;
    s.aw_valid = w_st_wr_xfer & ~r_aw_done & w_sel_aw_valid;
    s.aw_addr  = w_sel_aw_addr;
    s.w_valid  = w_st_wr_xfer & ~r_w_done & w_sel_w_valid;
    s.w_data   = w_sel_w_data;
    s.b_ready  = w_st_wr_resp & w_sel_b_ready;
  end

  // Master-side forwarding; only the granted master sees valids/readies,
  // data and response buses go to both.
  always_comb begin
    m0.ar_ready = ~r_gnt & w_st_rd_addr & s.ar_ready;
    m0.r_valid  = ~r_gnt & w_st_rd_data & s.r_valid;
    m0.aw_ready = ~r_gnt & w_st_wr_xfer & ~r_aw_done & s.aw_ready;
    m0.w_ready  = ~r_gnt & w_st_wr_xfer & ~r_w_done & s.w_ready;
    m0.b_valid  = ~r_gnt & w_st_wr_resp & s.b_valid;
    m0.r_data   = s.r_data;
    m0.r_resp   = s.r_resp;
    m0.b_resp   = s.b_resp;

    m1.ar_ready = r_gnt & w_st_rd_addr & s.ar_ready;
    m1.r_valid  = r_gnt & w_st_rd_data & s.r_valid;
    m1.aw_ready = r_gnt & w_st_wr_xfer & ~r_aw_done & s.aw_ready;
    m1.w_ready  = r_gnt & w_st_wr_xfer & ~r_w_done & s.w_ready;
    m1.b_valid  = r_gnt & w_st_wr_resp & s.b_valid;
    m1.r_data   = s.r_data;
    m1.r_resp   = s.r_resp;
    m1.b_resp   = s.b_resp;
  end

  // Transaction sequencing, grant bookkeeping and write-channel done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req0 | w_req1) begin
            r_gnt   <= w_nxt_gnt;
            r_state <= w_nxt_rd ? ST_RD_ADDR : ST_WR_XFER;
          end
        end
        ST_RD_ADDR: begin
          if (w_ar_hs) r_state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (w_r_hs) begin
            r_last  <= r_gnt;
            r_state <= ST_IDLE;
          end
        end
        ST_WR_XFER: begin
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= ST_WR_RESP;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (w_b_hs) begin
            r_last  <= r_gnt;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a small memory-backed slave model.
module tb_axi_lite_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_arbiter_if #(.ADDR_W(18), .DATA_W(16)) m0_if ();
  axi_lite_arbiter_if #(.ADDR_W(18), .DATA_W(16)) m1_if ();
  axi_lite_arbiter_if #(.ADDR_W(18), .DATA_W(16)) s_if ();

  axi_lite_arbiter #(.ADDR_W(18), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- slave model ----------------
  logic        sl_ar_ready, sl_aw_ready, sl_w_ready;
  logic        sl_aw_got, sl_w_got, sl_aw_hs, sl_w_hs;
  logic [7:0]  sl_waddr;
  logic [15:0] sl_wdata;
  logic [15:0] mem [0:255];

  assign s_if.ar_ready = sl_ar_ready;
  assign s_if.aw_ready = sl_aw_ready;
  assign s_if.w_ready  = sl_w_ready;
  assign s_if.r_resp   = 2'b00;
  assign s_if.b_resp   = 2'b00;
  assign sl_aw_hs = s_if.aw_valid & s_if.aw_ready;
  assign sl_w_hs  = s_if.w_valid & s_if.w_ready;

  always @(posedge clk) begin
    if (rst) begin
      s_if.r_valid <= 1'b0;
      s_if.r_data  <= 16'h0;
      s_if.b_valid <= 1'b0;
      sl_aw_got    <= 1'b0;
      sl_w_got     <= 1'b0;
      mem[8'h10]   <= 16'h1234;
    end else begin
      if (s_if.ar_valid && s_if.ar_ready) begin
        s_if.r_valid <= 1'b1;
        s_if.r_data  <= mem[s_if.ar_addr[7:0]];
      end else if (s_if.r_valid && s_if.r_ready) begin
        s_if.r_valid <= 1'b0;
      end
      if (s_if.b_valid && s_if.b_ready) s_if.b_valid <= 1'b0;
      if (sl_aw_hs) sl_waddr <= s_if.aw_addr[7:0];
      if (sl_w_hs)  sl_wdata <= s_if.w_data;
      if ((sl_aw_got || sl_aw_hs) && (sl_w_got || sl_w_hs)) begin
        mem[sl_aw_hs ? s_if.aw_addr[7:0] : sl_waddr] <= sl_w_hs ? s_if.w_data : sl_wdata;
        s_if.b_valid <= 1'b1;
        sl_aw_got    <= 1'b0;
        sl_w_got     <= 1'b0;
      end else begin
        if (sl_aw_hs) sl_aw_got <= 1'b1;
        if (sl_w_hs)  sl_w_got  <= 1'b1;
      end
    end
  end

  // ---------------- monitors ----------------
  int   cyc = 0;
  int   aw_cnt = 0;
  int   w_cnt = 0;
  int   ar_q[$];
  int   r_q[$];
  bit   g_q[$];
  int   d_q[$];
  int   done_q[$];
  logic m1_seen = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (s_if.ar_valid && s_if.ar_ready) ar_q.push_back(cyc);
      if (s_if.r_valid && s_if.r_ready) begin
        r_q.push_back(cyc);
        g_q.push_back(dut.r_gnt);
        d_q.push_back(int'(s_if.r_data));
        done_q.push_back(dut.r_gnt ? 2 : 0);
      end
      if (s_if.b_valid && s_if.b_ready) done_q.push_back(dut.r_gnt ? 3 : 1);
      if (sl_aw_hs) aw_cnt <= aw_cnt + 1;
      if (sl_w_hs)  w_cnt  <= w_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m1_if.ar_ready | m1_if.r_valid | m1_if.aw_ready | m1_if.w_ready | m1_if.b_valid)
      m1_seen <= 1'b1;
  end

  logic [14:0] all_vr;
  assign all_vr = {s_if.ar_valid, s_if.r_ready, s_if.aw_valid, s_if.w_valid, s_if.b_ready,
                   m0_if.ar_ready, m0_if.r_valid, m0_if.aw_ready, m0_if.w_ready, m0_if.b_valid,
                   m1_if.ar_ready, m1_if.r_valid, m1_if.aw_ready, m1_if.w_ready, m1_if.b_valid};

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; masters drop any valid whose handshake completed on that edge.
  task automatic step();
    bit f0ar, f0aw, f0w, f1ar, f1aw, f1w;
    @(negedge clk);
    f0ar = m0_if.ar_valid & m0_if.ar_ready;
    f0aw = m0_if.aw_valid & m0_if.aw_ready;
    f0w  = m0_if.w_valid  & m0_if.w_ready;
    f1ar = m1_if.ar_valid & m1_if.ar_ready;
    f1aw = m1_if.aw_valid & m1_if.aw_ready;
    f1w  = m1_if.w_valid  & m1_if.w_ready;
    @(posedge clk);
    #1;
    if (f0ar) m0_if.ar_valid = 1'b0;
    if (f0aw) m0_if.aw_valid = 1'b0;
    if (f0w)  m0_if.w_valid  = 1'b0;
    if (f1ar) m1_if.ar_valid = 1'b0;
    if (f1aw) m1_if.aw_valid = 1'b0;
    if (f1w)  m1_if.w_valid  = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rb;
    int db;
    int a0;
    int w0;
    logic [3:0] gord;

    rst = 1'b1;
    sl_ar_ready = 1'b1; sl_aw_ready = 1'b1; sl_w_ready = 1'b1;
    m0_if.ar_valid = 0; m0_if.ar_addr = '0; m0_if.r_ready = 0;
    m0_if.aw_valid = 0; m0_if.aw_addr = '0; m0_if.w_valid = 0; m0_if.w_data = '0; m0_if.b_ready = 0;
    m1_if.ar_valid = 0; m1_if.ar_addr = '0; m1_if.r_ready = 0;
    m1_if.aw_valid = 0; m1_if.aw_addr = '0; m1_if.w_valid = 0; m1_if.w_data = '0; m1_if.b_ready = 0;

    // Reset state
    step();
    step();
    chk("rst_outs", 32'(all_vr), 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'd0);
    chk("rst_last", 32'(dut.r_last), 32'd1);
    chk("rst_gnt", 32'(dut.r_gnt), 32'd0);
    rst = 1'b0;
    step();

    // Single read by m0
    m0_if.ar_valid = 1; m0_if.ar_addr = 18'h00010; m0_if.r_ready = 1;
    #1;
    chk("rd1_idle_arv", 32'(s_if.ar_valid), 32'd0);
    step();
    chk("rd1_s_arv", 32'(s_if.ar_valid), 32'd1);
    chk("rd1_s_addr", 32'(s_if.ar_addr), 32'h10);
    chk("rd1_m0_arready", 32'(m0_if.ar_ready), 32'd1);
    step();
    chk("rd1_m0_rvalid", 32'(m0_if.r_valid), 32'd1);
    chk("rd1_m0_rdata", 32'(m0_if.r_data), 32'h1234);
    chk("rd1_m0_rresp", 32'(m0_if.r_resp), 32'd0);
    chk("rd1_s_rready", 32'(s_if.r_ready), 32'd1);
    step();
    chk("rd1_back_idle", 32'(dut.r_state), 32'd0);
    chk("rd1_m0_rvalid_low", 32'(m0_if.r_valid), 32'd0);
    chk("rd1_m1_quiet", 32'(m1_seen), 32'd0);
    m0_if.r_ready = 0;

    // m1 write, w raised two cycles before aw, aw accepted late
    m1_if.w_valid = 1; m1_if.w_data = 16'hBEEF; m1_if.b_ready = 1;
    step();
    step();
    chk("wr1_w_only_idle", 32'(dut.r_state), 32'd0);
    chk("wr1_w_only_sw", 32'(s_if.w_valid), 32'd0);
    sl_aw_ready = 0;
    m1_if.aw_valid = 1; m1_if.aw_addr = 18'h00020;
    step();
    chk("wr1_gnt", 32'(dut.r_gnt), 32'd1);
    chk("wr1_s_awv_wv", 32'({s_if.aw_valid, s_if.w_valid}), 32'b11);
    chk("wr1_m1_wready", 32'(m1_if.w_ready), 32'd1);
    step();
    chk("wr1_w_done", 32'(dut.r_w_done), 32'd1);
    chk("wr1_sw_gated", 32'(s_if.w_valid), 32'd0);
    chk("wr1_still_xfer", 32'(dut.r_state), 32'd3);
    sl_aw_ready = 1;
    step();
    chk("wr1_resp_state", 32'(dut.r_state), 32'd4);
    chk("wr1_m1_bvalid", 32'(m1_if.b_valid), 32'd1);
    chk("wr1_m0_bvalid", 32'(m0_if.b_valid), 32'd0);
    chk("wr1_bresp", 32'(m1_if.b_resp), 32'd0);
    step();
    chk("wr1_idle", 32'(dut.r_state), 32'd0);
    chk("wr1_m1_bvalid_low", 32'(m1_if.b_valid), 32'd0);

    // Read back 0x20 through m1
    m1_if.ar_valid = 1; m1_if.ar_addr = 18'h00020; m1_if.r_ready = 1;
    n = 0;
    while (!m1_if.r_valid && n < 10) begin step(); n++; end
    chk("rd20_rvalid", 32'(m1_if.r_valid), 32'd1);
    chk("rd20_rdata", 32'(m1_if.r_data), 32'hBEEF);
    step();

    // Simultaneous aw/w handshake (m1)
    a0 = aw_cnt; w0 = w_cnt;
    m1_if.aw_valid = 1; m1_if.aw_addr = 18'h00030;
    m1_if.w_valid = 1;  m1_if.w_data = 16'h5A5A;
    step();
    chk("sim_both_valid", 32'({s_if.aw_valid, s_if.w_valid}), 32'b11);
    step();
    chk("sim_wr_resp", 32'(dut.r_state), 32'd4);
    chk("sim_valids_low", 32'({s_if.aw_valid, s_if.w_valid}), 32'b00);
    chk("sim_flags_clr", 32'({dut.r_aw_done, dut.r_w_done}), 32'b00);
    step();
    step();
    step();
    chk("sim_aw_once", 32'(aw_cnt - a0), 32'd1);
    chk("sim_w_once", 32'(w_cnt - w0), 32'd1);
    chk("sim_mem30", 32'(mem[8'h30]), 32'h5A5A);

    // Contention: both masters read continuously
    rb = r_q.size();
    m0_if.ar_addr = 18'h00010; m0_if.r_ready = 1;
    m1_if.ar_addr = 18'h00020; m1_if.r_ready = 1;
    m0_if.ar_valid = 1; m1_if.ar_valid = 1;
    n = 0;
    while ((r_q.size() - rb) < 4 && n < 60) begin
      step();
      n++;
      if ((r_q.size() - rb) >= 4) begin
        m0_if.ar_valid = 0; m1_if.ar_valid = 0;
      end else begin
        m0_if.ar_valid = 1; m1_if.ar_valid = 1;
      end
    end
    m0_if.ar_valid = 0; m1_if.ar_valid = 0;
    step();
    chk("cont_count", 32'(r_q.size() - rb), 32'd4);
    if ((r_q.size() - rb) >= 4) begin
      gord = {g_q[rb], g_q[rb+1], g_q[rb+2], g_q[rb+3]};
      chk("cont_order", 32'(gord), 32'b0101);
      for (int i = 0; i < 4; i++)
        chk("cont_data", 32'(d_q[rb+i]), (i % 2 == 0) ? 32'h1234 : 32'hBEEF);
      for (int i = 0; i < 3; i++)
        chk("cont_gap", 32'(ar_q[ar_q.size()-4+i+1] - r_q[rb+i]), 32'd2);
    end

    // Same-master read+write with m1 also requesting
    db = done_q.size();
    m0_if.ar_valid = 1; m0_if.ar_addr = 18'h00010;
    m0_if.aw_valid = 1; m0_if.aw_addr = 18'h00040;
    m0_if.w_valid = 1;  m0_if.w_data = 16'h7777; m0_if.b_ready = 1;
    m1_if.ar_valid = 1; m1_if.ar_addr = 18'h00020;
    n = 0;
    while ((done_q.size() - db) < 3 && n < 60) begin step(); n++; end
    step();
    chk("rw_count", 32'(done_q.size() - db), 32'd3);
    if ((done_q.size() - db) >= 3) begin
      chk("rw_first_m0_read", 32'(done_q[db]), 32'd0);
      chk("rw_second_m1_read", 32'(done_q[db+1]), 32'd2);
      chk("rw_third_m0_write", 32'(done_q[db+2]), 32'd1);
    end
    chk("rw_mem40", 32'(mem[8'h40]), 32'h7777);

    // Reset in WR_XFER after aw only
    sl_w_ready = 0;
    m0_if.aw_valid = 1; m0_if.aw_addr = 18'h00050;
    m0_if.w_valid = 1;  m0_if.w_data = 16'h1111;
    step();
    step();
    chk("rstw_aw_done", 32'(dut.r_aw_done), 32'd1);
    chk("rstw_xfer", 32'(dut.r_state), 32'd3);
    rst = 1'b1;
    step();
    chk("rstw_outs", 32'(all_vr), 32'h0);
    chk("rstw_state", 32'(dut.r_state), 32'd0);
    chk("rstw_last", 32'(dut.r_last), 32'd1);
    chk("rstw_aw_done_clr", 32'(dut.r_aw_done), 32'd0);
    rst = 1'b0;
    sl_w_ready = 1;
    m0_if.aw_valid = 1;
    n = 0;
    while (!m0_if.b_valid && n < 20) begin step(); n++; end
    chk("rstw_new_bvalid", 32'(m0_if.b_valid), 32'd1);
    step();
    chk("rstw_mem50", 32'(mem[8'h50]), 32'h1111);
    chk("rstw_idle", 32'(dut.r_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master, one-slave AXI-lite arbiter that shares the single `bram_axi` instance between the UART debug master (m0) and a second on-chip master (m1). It serialises whole transactions: exactly one read or one write is outstanding at the slave at any time, and grants rotate round-robin between masters. It sits between `uart_debug` (plus the future second master) and `bram_axi`, inside the top level.

## Interface
Parameters:
- `ADDR_W`, 18: address width of every ar/aw channel.
- `DATA_W`, 16: data width of every w/r channel.

Ports. "mN_" denotes a pair of ports, m0_ and m1_, with identical width and direction.
- `clk`  input  1  sole clock; all logic is on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `mN_ar_valid` / `mN_ar_addr`  input  1 / ADDR_W  master read-address request.
- `mN_ar_ready`  output  1  read-address accepted.
- `mN_r_valid`  output  1  read data valid.
- `mN_r_data` / `mN_r_resp`  output  DATA_W / 2  read data and response.
- `mN_r_ready`  input  1  master accepts read data.
- `mN_aw_valid` / `mN_aw_addr`  input  1 / ADDR_W  write-address request.
- `mN_aw_ready`  output  1  write-address accepted.
- `mN_w_valid` / `mN_w_data`  input  1 / DATA_W  write data.
- `mN_w_ready`  output  1  write data accepted.
- `mN_b_valid` / `mN_b_resp`  output  1 / 2  write response.
- `mN_b_ready`  input  1  master accepts response.
- `s_ar_*`, `s_r_*`, `s_aw_*`, `s_w_*`, `s_b_*`: slave-side mirror of the same signals, with directions reversed, connected to `bram_axi`.

## Operation
- State machine: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP. Registers: `state`, `gnt` (granted master, 1 bit), `last` (master of the last completed transaction), `aw_done`, `w_done`.
- Request of master N: `mN_ar_valid | mN_aw_valid`.
- IDLE:
  - If only one master requests, grant that master.
  - If both request, grant `~last`.
  - For the granted master: if its `ar_valid` is high, go to RD_ADDR; otherwise go to WR_XFER. Reads win over a simultaneous write from the same master.
  - No request: stay in IDLE.
- RD_ADDR:
  - `s_ar_valid`/`s_ar_addr` come from the granted master; `s_ar_ready` is routed to its `ar_ready`.
  - On the handshake, go to RD_DATA.
- RD_DATA:
  - `s_r_*` is routed to the granted master and `r_ready` is routed back to the slave.
  - On the r handshake: set `last <= gnt` and return to IDLE.
- WR_XFER:
  - aw and w are forwarded independently. Each channel's valid is gated by the inverse of its own done flag.
  - The aw handshake sets `aw_done`; the w handshake sets `w_done`. Both may occur in the same cycle.
  - When both are done (registered flags or same-cycle handshakes), clear the flags and go to WR_RESP.
- WR_RESP:
  - `s_b_*` is forwarded to the granted master.
  - On the b handshake: set `last <= gnt` and return to IDLE.
- The non-granted master, and all masters in IDLE, see every ready and valid output at 0.
- Data and response buses (`r_data`, `r_resp`, `b_resp`) are driven to both masters unconditionally; only the valids are gated.
- Slave-side valids are 0 in IDLE and in any state that does not own the channel.
- Slave `s_*_addr` and `s_w_data` are muxed by `gnt`; their value when the matching valid is 0 is don't-care.

## Timing
- Reset: `state`=IDLE, `gnt`=0, `last`=1 (so m0 wins the first tie), `aw_done`=`w_done`=0. Every valid and ready output reads 0 in the cycle after `rst` is sampled high.
- Arbitration latency: a request seen in IDLE at edge k puts the forwarded valid on the slave side in cycle k+1.
- All forwarding within a state is combinational, with zero added latency per handshake.
- After a completing r or b handshake, the next IDLE decision happens on the following edge. Minimum turnaround between transactions is therefore 1 idle cycle.
- Reset mid-transaction: reset aborts the transaction. The arbiter returns to IDLE and drops all valids immediately. The slave is reset alongside it, so no recovery is attempted.
- A master that deasserts its request after the grant but before the handshake violates AXI. Behaviour in that case is unspecified; the state is held.
- Fairness: under continuous requests from both masters, grants strictly alternate m0, m1, m0, …

## Test plan
- Single read: m0 reads 0x00010 and the slave returns 0x1234 → `s_ar_valid` rises 1 cycle after `m0_ar_valid`; m0 receives `r_data`=0x1234, `r_resp`=0; `m1_*` valids/readies stay 0 throughout.
- Write with w before aw: m1 raises w (0xBEEF) 2 cycles before aw (addr 0x00020) → both handshakes complete, `s_b_valid` is routed to `m1_b_valid`, and a subsequent read of 0x00020 returns 0xBEEF.
- Simultaneous aw/w handshake in one cycle → WR_RESP entered on the next edge; no duplicate `s_aw_valid` or `s_w_valid` pulse afterwards.
- Contention: both masters request reads continuously for 4 transactions → grant order m0, m1, m0, m1, with exactly 1 idle cycle between transactions.
- Same-master read+write: m0 asserts `ar_valid` and `aw_valid` together → the read is served first and the write is served on the next m0 grant (after m1 if m1 is requesting).
- Reset mid-write: assert `rst` in WR_XFER after the aw handshake only → next cycle all valid and ready outputs are 0, state is IDLE, `last`=1; a fresh m0 write then completes normally.
